// File: rtl/memory_access_pkg.sv
// Shared stage definitions for the memory-access stage: FSM encoding and counter sizing.
package memory_access_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Wide enough for the largest legal TIMEOUT_CYCLES (255).
  localparam int CNT_WIDTH = 8;

endpackage

// File: rtl/memory_access_if.sv
// Data-memory request/response bus between the memory-access stage and the data memory.
interface memory_access_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  dmem_req_out;
  logic                  dmem_we_out;
  logic [DATA_WIDTH-1:0] dmem_addr_out;
  logic [DATA_WIDTH-1:0] dmem_wdata_out;
  logic [DATA_WIDTH-1:0] dmem_rdata_in;
  logic                  dmem_ack_in;

  modport master (
    output dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out,
    input  dmem_rdata_in, dmem_ack_in
  );

  modport slave (
    input  dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out,
    output dmem_rdata_in, dmem_ack_in
  );

endinterface

// File: rtl/memory_access_pipe.sv
// Write-back pipe register: loads new controls, loads a bubble, or holds; load data has its own enable.
module memory_access_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      bubble,
  input  logic                      rd_load,
  input  logic [DATA_WIDTH-1:0]     wb_alu_data,
  input  logic                      wb_reg_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] wb_reg_wr_addr,
  input  logic                      wb_sel,
  input  logic [DATA_WIDTH-1:0]     wb_rd_data,
  output logic [DATA_WIDTH-1:0]     alu_data,
  output logic                      reg_wr_en,
  output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr,
  output logic                      sel,
  output logic [DATA_WIDTH-1:0]     rd_data
);

  // Write-back controls; a bubble wins over a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_data    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      sel         <= 1'b0;
    end else if (bubble) begin
      alu_data    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      sel         <= 1'b0;
    end else if (load) begin
      alu_data    <= wb_alu_data;
      reg_wr_en   <= wb_reg_wr_en;
      reg_wr_addr <= wb_reg_wr_addr;
      sel         <= wb_sel;
    end
  end

  // Load data only changes when a load completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_load) begin
      rd_data <= wb_rd_data;
    end
  end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues loads/stores to data memory, stalls upstream, times out hung accesses.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_data_rd_en_in,
  input  logic                      mem_data_wr_en_in,
  input  logic [DATA_WIDTH-1:0]     mem_data_in,
  input  logic [DATA_WIDTH-1:0]     alu_data_in,
  input  logic                      reg_wr_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
  input  logic                      write_back_mux_sel_in,
  memory_access_if.master           dmem,
  output logic [DATA_WIDTH-1:0]     mem_rd_data_out,
  output logic [DATA_WIDTH-1:0]     alu_data_out,
  output logic                      reg_wr_en_out,
  output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
  output logic                      write_back_mux_sel_out,
  output logic                      stall_out,
  output logic                      bus_error_out
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                    state_r;
  logic [CNT_WIDTH-1:0]      cnt_r;
  logic [DATA_WIDTH-1:0]     addr_r;
  logic [DATA_WIDTH-1:0]     wdata_r;
  logic                      we_r;
  logic                      lat_wr_en_r;
  logic [REG_ADDR_WIDTH-1:0] lat_wr_addr_r;
  logic                      lat_sel_r;
  logic                      bus_error_r;

  logic                      req_s;
  logic                      ack_s;
  logic                      wb_load_s;
  logic                      wb_bubble_s;
  logic                      rd_load_s;
  logic [DATA_WIDTH-1:0]     wb_alu_s;
  logic                      wb_wr_en_s;
  logic [REG_ADDR_WIDTH-1:0] wb_wr_addr_s;
  logic                      wb_sel_s;

  assign req_s = mem_data_rd_en_in | mem_data_wr_en_in;
  assign ack_s = dmem.dmem_ack_in;

  // Access FSM with latched request and timeout counter; ack beats timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      addr_r        <= '0;
      wdata_r       <= '0;
      we_r          <= 1'b0;
      lat_wr_en_r   <= 1'b0;
      lat_wr_addr_r <= '0;
      lat_sel_r     <= 1'b0;
      bus_error_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          bus_error_r <= 1'b0;
          if (req_s) begin
            state_r       <= ACCESS;
            cnt_r         <= '0;
            addr_r        <= alu_data_in;
            wdata_r       <= mem_data_in;
            we_r          <= mem_data_wr_en_in;
            lat_wr_en_r   <= reg_wr_en_in;
            lat_wr_addr_r <= reg_wr_addr_in;
            lat_sel_r     <= write_back_mux_sel_in;
          end
        end
        ACCESS: begin
          if (ack_s) begin
            state_r     <= IDLE;
            bus_error_r <= 1'b0;
          end else if (cnt_r == TIMEOUT_LAST) begin
            state_r     <= IDLE;
            bus_error_r <= 1'b1;
          end else begin
            cnt_r       <= cnt_r + CNT_WIDTH'(1);
            bus_error_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          bus_error_r <= 1'b0;
        end
      endcase
    end
  end

  // Selects what the write-back register takes at the next edge.
  always_comb begin
    wb_load_s    = 1'b0;
    wb_bubble_s  = 1'b0;
    rd_load_s    = 1'b0;
    wb_alu_s     = alu_data_in;
    wb_wr_en_s   = reg_wr_en_in;
    wb_wr_addr_s = reg_wr_addr_in;
    wb_sel_s     = write_back_mux_sel_in;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          wb_bubble_s = 1'b1;
        end else begin
          wb_load_s = 1'b1;
        end
      end
      ACCESS: begin
        if (ack_s) begin
          wb_load_s    = 1'b1;
          rd_load_s    = ~we_r;
          wb_alu_s     = addr_r;
          wb_wr_en_s   = lat_wr_en_r;
          wb_wr_addr_s = lat_wr_addr_r;
          wb_sel_s     = lat_sel_r;
        end else begin
          wb_bubble_s = 1'b1;
        end
      end
      default: begin
        wb_bubble_s = 1'b1;
      end
    endcase
  end

  assign stall_out           = ((state_r == IDLE) && req_s) || ((state_r == ACCESS) && !ack_s);
  assign bus_error_out       = bus_error_r;
  assign dmem.dmem_req_out   = (state_r == ACCESS);
  assign dmem.dmem_we_out    = we_r;
  assign dmem.dmem_addr_out  = addr_r;
  assign dmem.dmem_wdata_out = wdata_r;

  memory_access_pipe #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_pipe (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (wb_load_s),
    .bubble         (wb_bubble_s),
    .rd_load        (rd_load_s),
    .wb_alu_data    (wb_alu_s),
    .wb_reg_wr_en   (wb_wr_en_s),
    .wb_reg_wr_addr (wb_wr_addr_s),
    .wb_sel         (wb_sel_s),
    .wb_rd_data     (dmem.dmem_rdata_in),
    .alu_data       (alu_data_out),
    .reg_wr_en      (reg_wr_en_out),
    .reg_wr_addr    (reg_wr_addr_out),
    .sel            (write_back_mux_sel_out),
    .rd_data        (mem_rd_data_out)
  );

endmodule

// File: tb/tb_memory_access.sv
// Randomized self-checking bench for memory_access against a transaction-level reference model.
module tb_memory_access;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic [DW-1:0] alu_in = '0;
  logic          wen_in = 1'b0;
  logic [AW-1:0] waddr_in = '0;
  logic          sel_in = 1'b0;
  logic [DW-1:0] rd_data_out;
  logic [DW-1:0] alu_out;
  logic          wen_out;
  logic [AW-1:0] waddr_out;
  logic          sel_out;
  logic          stall;
  logic          berr;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_rd = '0;

  memory_access_if #(.DATA_WIDTH(DW)) dmem_bus ();

  memory_access #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .mem_data_rd_en_in      (rd_en),
    .mem_data_wr_en_in      (wr_en),
    .mem_data_in            (mem_data),
    .alu_data_in            (alu_in),
    .reg_wr_en_in           (wen_in),
    .reg_wr_addr_in         (waddr_in),
    .write_back_mux_sel_in  (sel_in),
    .dmem                   (dmem_bus.master),
    .mem_rd_data_out        (rd_data_out),
    .alu_data_out           (alu_out),
    .reg_wr_en_out          (wen_out),
    .reg_wr_addr_out        (waddr_out),
    .write_back_mux_sel_out (sel_out),
    .stall_out              (stall),
    .bus_error_out          (berr)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Non-memory op: expect write-back of the inputs one edge later, no stall; ack in IDLE ignored.
  task automatic alu_op(input logic [DW-1:0] a, input logic en, input logic [AW-1:0] wa, input logic s);
    rd_en = 1'b0; wr_en = 1'b0; alu_in = a; mem_data = $urandom;
    wen_in = en; waddr_in = wa; sel_in = s;
    dmem_bus.dmem_ack_in = 1'($urandom_range(0, 1));
    dmem_bus.dmem_rdata_in = $urandom;
    #1;
    check_value("alu_stall", 32'(stall), 32'd0);
    check_value("alu_req", 32'(dmem_bus.dmem_req_out), 32'd0);
    @(posedge clk); #1;
    check_value("alu_data", alu_out, a);
    check_value("alu_wen", 32'(wen_out), 32'(en));
    check_value("alu_waddr", 32'(waddr_out), 32'(wa));
    check_value("alu_sel", 32'(sel_out), 32'(s));
    check_value("alu_rddata", rd_data_out, exp_rd);
    check_value("alu_berr", 32'(berr), 32'd0);
    dmem_bus.dmem_ack_in = 1'b0;
  endtask

  // Memory op: ack_at is the 0-based ACCESS cycle carrying ack, or -1 for none (timeout).
  task automatic mem_op(input logic rd, input logic wr, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                        input int ack_at, input logic [DW-1:0] rdata,
                        input logic en, input logic [AW-1:0] wa, input logic s);
    logic is_store;
    int stalls;
    is_store = wr;
    stalls = 0;
    rd_en = rd; wr_en = wr; alu_in = a; mem_data = wd;
    wen_in = en; waddr_in = wa; sel_in = s;
    dmem_bus.dmem_ack_in = 1'b0;
    #1;
    check_value("idle_stall", 32'(stall), 32'd1);
    check_value("idle_req", 32'(dmem_bus.dmem_req_out), 32'd0);
    stalls += int'(stall);
    @(posedge clk); #1;
    check_value("entry_bubble", 32'(wen_out), 32'd0);
    check_value("entry_berr", 32'(berr), 32'd0);
    for (int k = 0; k < TO; k++) begin
      rd_en = 1'($urandom); wr_en = 1'($urandom); alu_in = $urandom; mem_data = $urandom;
      wen_in = 1'($urandom); waddr_in = AW'($urandom); sel_in = 1'($urandom);
      dmem_bus.dmem_ack_in = (k == ack_at);
      dmem_bus.dmem_rdata_in = (k == ack_at) ? rdata : $urandom;
      #1;
      check_value("acc_req", 32'(dmem_bus.dmem_req_out), 32'd1);
      check_value("acc_addr", dmem_bus.dmem_addr_out, a);
      check_value("acc_we", 32'(dmem_bus.dmem_we_out), 32'(is_store));
      if (is_store) check_value("acc_wdata", dmem_bus.dmem_wdata_out, wd);
      check_value("acc_stall", 32'(stall), (k == ack_at) ? 32'd0 : 32'd1);
      stalls += int'(stall);
      @(posedge clk); #1;
      if (k == ack_at) begin
        if (!is_store) exp_rd = rdata;
        check_value("ack_alu", alu_out, a);
        check_value("ack_wen", 32'(wen_out), 32'(en));
        check_value("ack_waddr", 32'(waddr_out), 32'(wa));
        check_value("ack_sel", 32'(sel_out), 32'(s));
        check_value("ack_rddata", rd_data_out, exp_rd);
        check_value("ack_berr", 32'(berr), 32'd0);
        check_value("ack_stalls", 32'(stalls), 32'(ack_at + 1));
        break;
      end else if (k == TO - 1) begin
        check_value("to_berr", 32'(berr), 32'd1);
        check_value("to_wen", 32'(wen_out), 32'd0);
        check_value("to_rddata", rd_data_out, exp_rd);
        check_value("to_stalls", 32'(stalls), 32'(TO + 1));
      end else begin
        check_value("acc_bubble", 32'(wen_out), 32'd0);
        check_value("acc_berr", 32'(berr), 32'd0);
      end
    end
    dmem_bus.dmem_ack_in = 1'b0;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind;
    int r;
    dmem_bus.dmem_ack_in = 1'b0;
    dmem_bus.dmem_rdata_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_req", 32'(dmem_bus.dmem_req_out), 32'd0);
    check_value("rst_wen", 32'(wen_out), 32'd0);
    check_value("rst_alu", alu_out, 32'd0);
    check_value("rst_rddata", rd_data_out, 32'd0);
    check_value("rst_berr", 32'(berr), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    alu_op(32'h0000_0042, 1'b1, 5'd3, 1'b0);
    mem_op(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF, 1'b1, 5'd7, 1'b1);
    mem_op(1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 0, 32'h5555_AAAA, 1'b0, 5'd0, 1'b0);
    mem_op(1'b1, 1'b0, 32'h0000_0300, 32'h0, -1, 32'h0, 1'b1, 5'd9, 1'b1);
    alu_op(32'h0000_0077, 1'b1, 5'd4, 1'b1);
    mem_op(1'b1, 1'b0, 32'h0000_0400, 32'h0, TO - 1, 32'hCAFE_F00D, 1'b1, 5'd12, 1'b1);

    // Reset in the second ACCESS cycle must drop the request without a clock edge.
    rd_en = 1'b1; wr_en = 1'b0; alu_in = 32'h0000_0500; wen_in = 1'b1; waddr_in = 5'd1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    @(posedge clk); #1;
    check_value("pre_rst_req", 32'(dmem_bus.dmem_req_out), 32'd1);
    rst_n = 1'b0;
    #1;
    check_value("arst_req", 32'(dmem_bus.dmem_req_out), 32'd0);
    check_value("arst_stall", 32'(stall), 32'd0);
    check_value("arst_rddata", rd_data_out, 32'd0);
    exp_rd = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    alu_op(32'h0000_0099, 1'b1, 5'd5, 1'b0);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        alu_op($urandom, 1'($urandom), AW'($urandom), 1'($urandom));
      end else begin
        r = $urandom_range(0, TO + 2);
        mem_op((kind != 5), (kind >= 5), $urandom, $urandom, (r >= TO) ? -1 : r, $urandom,
               1'($urandom), AW'($urandom), 1'($urandom));
      end
    end
    alu_op(32'h0000_00AA, 1'b0, 5'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data and address width.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5: register-file address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum ACCESS cycles before bus error; legal range 2..255.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-006 SHALL have ports mem_data_rd_en_in, mem_data_wr_en_in  input  1 each  load and store request from the execute pipe.
REQ-007 SHALL have ports mem_data_in, alu_data_in  input  DATA_WIDTH each  store data; ALU result, which is also the memory address.
REQ-008 SHALL have ports reg_wr_en_in  input  1, reg_wr_addr_in  input  REG_ADDR_WIDTH, write_back_mux_sel_in  input  1  write-back control.
REQ-009 SHALL have ports dmem_req_out  output  1, dmem_we_out  output  1, dmem_addr_out  output  DATA_WIDTH, dmem_wdata_out  output  DATA_WIDTH  data-memory request.
REQ-010 SHALL have ports dmem_rdata_in  input  DATA_WIDTH, dmem_ack_in  input  1  data-memory response.
REQ-011 SHALL have ports mem_rd_data_out  output  DATA_WIDTH, alu_data_out  output  DATA_WIDTH, reg_wr_en_out  output  1, reg_wr_addr_out  output  REG_ADDR_WIDTH, write_back_mux_sel_out  output  1  write-back pipe register.
REQ-012 SHALL have ports stall_out  output  1  freeze upstream; bus_error_out  output  1  one-cycle timeout pulse.

Function
REQ-013 SHALL implement FSM with states IDLE and ACCESS.
REQ-014 SHALL, in IDLE with neither rd_en nor wr_en set, load the inputs into the write-back register at the next edge (latency 1), with mem_rd_data_out unchanged.
REQ-015 SHALL, in IDLE with rd_en or wr_en set, latch address, write data, we (= wr_en) and the write-back controls, then enter ACCESS; a bubble (reg_wr_en_out=0) SHALL be loaded into the write-back register at that edge.
REQ-016 SHALL treat rd_en and wr_en both set as a store.
REQ-017 SHALL drive dmem_req_out=1 for every ACCESS cycle, with addr, wdata and we held stable from the latched values; dmem_req_out=0 in IDLE.
REQ-018 SHALL drive stall_out combinationally: 1 in an IDLE cycle with a memory request; 1 in ACCESS cycles without dmem_ack_in; 0 otherwise, including the ack cycle.
REQ-019 SHALL, on dmem_ack_in in ACCESS, capture dmem_rdata_in (load) into mem_rd_data_out and load the latched controls into the write-back register, then return to IDLE; the result is visible the cycle after ack.
REQ-020 SHALL ignore upstream inputs while in ACCESS and SHALL load bubbles into the write-back register during non-ack ACCESS cycles.
REQ-021 SHALL count ACCESS cycles; when the count reaches TIMEOUT_CYCLES-1 without ack, it SHALL pulse bus_error_out for one cycle, load a bubble, and return to IDLE.
REQ-022 SHALL give ack priority over timeout when both occur in the same cycle; the counter SHALL clear on every entry to ACCESS.
REQ-023 SHALL ignore dmem_ack_in in IDLE.

Reset
REQ-024 SHALL, on rst_n low, asynchronously enter IDLE and clear the counter and all outputs to 0, dropping dmem_req_out immediately even mid-access.
REQ-025 SHALL, on deassertion, begin operation at the first rising edge with rst_n high.

Structure
REQ-026 SHALL take state encodings (IDLE=0, ACCESS=1) from the shared stage-definitions include file.
REQ-027 SHALL place the write-back register in one sub-module, memory_access_pipe, with bubble-load and enable controls.

Verification
REQ-028 ALU op, alu_data_in=0x0000_0042, reg_wr_en_in=1, addr 3 -> next cycle alu_data_out=0x42, reg_wr_en_out=1, reg_wr_addr_out=3, stall_out never high.
REQ-029 Load at address 0x100, ack after 3 ACCESS cycles with rdata 0xDEAD_BEEF -> stall_out high for 3 cycles then low; dmem_addr_out=0x100 while the request is held; mem_rd_data_out=0xDEADBEEF the cycle after ack.
REQ-030 Store with wr_en and rd_en both set, data 0x1234_5678, immediate ack -> dmem_we_out=1, dmem_wdata_out=0x12345678, exactly one ACCESS cycle.
REQ-031 Load, no ack -> bus_error_out pulses once after 16 ACCESS cycles; reg_wr_en_out stays 0; FSM in IDLE next cycle.
REQ-032 rst_n low during ACCESS cycle 2 -> dmem_req_out=0 and stall_out=0 without a clock edge; after release, an ALU op passes with latency 1.
REQ-033 ack asserted in the same cycle as the timeout -> data captured, bus_error_out stays 0.
